// File: rtl/bp_gshare_tagged_if.sv
// bp_gshare_tagged_if: fetch/prediction, resolution and rollback bundle for the branch predictor.
interface bp_gshare_tagged_if #(
    parameter int N_FETCH   = 2,
    parameter int N_RES     = 2,
    parameter int GHR_BITS  = 8,
    parameter int ROB_IDX_W = 5
);
    logic [N_FETCH-1:0]                fetch_valid;
    logic [N_FETCH-1:0][63:0]          fetch_pc;
    logic [N_FETCH-1:0]                fetch_is_cond;
    logic [N_FETCH-1:0]                fetch_is_uncond;
    logic [N_FETCH-1:0]                pred_valid;
    logic [N_FETCH-1:0]                pred_taken;
    logic [N_FETCH-1:0][GHR_BITS-1:0]  pred_ghr;
    logic [63:0]                       pred_target;
    logic [N_RES-1:0]                  res_valid;
    logic [N_RES-1:0]                  res_is_cond;
    logic [N_RES-1:0][63:0]            res_pc;
    logic [N_RES-1:0]                  res_taken;
    logic [N_RES-1:0][63:0]            res_target;
    logic [N_RES-1:0][63:0]            res_pred_target;
    logic [N_RES-1:0][GHR_BITS-1:0]    res_ghr;
    logic [N_RES-1:0][ROB_IDX_W-1:0]   res_rob_idx;
    logic [ROB_IDX_W-1:0]              rob_head_idx;
    logic                              rollback_en;
    logic [ROB_IDX_W-1:0]              rollback_rob_idx;
    logic [63:0]                       rollback_pc;
    logic [31:0]                       mispredict_cnt;

    modport master (
        output fetch_valid, fetch_pc, fetch_is_cond, fetch_is_uncond,
        output res_valid, res_is_cond, res_pc, res_taken, res_target, res_pred_target,
        output res_ghr, res_rob_idx, rob_head_idx,
        input  pred_valid, pred_taken, pred_ghr, pred_target,
        input  rollback_en, rollback_rob_idx, rollback_pc, mispredict_cnt
    );
    modport slave (
        input  fetch_valid, fetch_pc, fetch_is_cond, fetch_is_uncond,
        input  res_valid, res_is_cond, res_pc, res_taken, res_target, res_pred_target,
        input  res_ghr, res_rob_idx, rob_head_idx,
        output pred_valid, pred_taken, pred_ghr, pred_target,
        output rollback_en, rollback_rob_idx, rollback_pc, mispredict_cnt
    );
endinterface

// File: rtl/bp_gshare_tagged.sv
// bp_gshare_tagged: multi-lane branch predictor (2-bit BHT, tagged BTB, speculative GHR) with oldest-mispredict rollback.
// BP_GSHARE_EN selects gshare history indexing; without it the BHT is bimodal and no GHR exists.
module bp_gshare_tagged #(
    parameter int N_FETCH      = 2,
    parameter int N_RES        = 2,
    parameter int BHT_IDX_BITS = 8,
    parameter int BTB_IDX_BITS = 6,
    parameter int BTB_TAG_BITS = 10,
    parameter int GHR_BITS     = 8,
    parameter int ROB_IDX_W    = 5
) (
    input logic clock,
    input logic reset_n,
    bp_gshare_tagged_if.slave bus
);
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif
    localparam int WIN_W = (N_RES > 1) ? $clog2(N_RES) : 1;

    logic [1:0]              bht        [1<<BHT_IDX_BITS];
    logic                    btb_valid  [1<<BTB_IDX_BITS];
    logic [BTB_TAG_BITS-1:0] btb_tag    [1<<BTB_IDX_BITS];
    logic [63:0]             btb_target [1<<BTB_IDX_BITS];
    logic [GHR_BITS-1:0]     ghr;

    logic [N_RES-1:0][63:0]              res_corr;
    logic [N_RES-1:0][ROB_IDX_W-1:0]     res_age;
    logic [N_RES-1:0][BHT_IDX_BITS-1:0]  res_bht;
    logic [N_RES-1:0][BTB_IDX_BITS-1:0]  res_btb;
    logic [N_RES-1:0][BTB_TAG_BITS-1:0]  res_tag;
    logic [N_RES-1:0]                    train;
    logic [WIN_W-1:0]                    win;

    always_comb begin
        logic found;
        logic [ROB_IDX_W-1:0] win_age;
        found = 1'b0;
        win = '0;
        win_age = '0;
        for (int k = 0; k < N_RES; k++) begin
            res_corr[k] = bus.res_taken[k] ? bus.res_target[k] : bus.res_pc[k] + 64'd4;
            res_age[k] = bus.res_rob_idx[k] - bus.rob_head_idx;
            res_bht[k] = bus.res_pc[k][BHT_IDX_BITS+1:2] ^ (GSHARE ? BHT_IDX_BITS'(bus.res_ghr[k]) : '0);
            res_btb[k] = bus.res_pc[k][BTB_IDX_BITS+1:2];
            res_tag[k] = bus.res_pc[k][BTB_TAG_BITS+BTB_IDX_BITS+1:BTB_IDX_BITS+2];
            // strict < keeps the lowest port on equal age
            if (bus.res_valid[k] && res_corr[k] != bus.res_pred_target[k] && (!found || res_age[k] < win_age)) begin
                found = 1'b1;
                win = WIN_W'(k);
                win_age = res_age[k];
            end
        end
        for (int k = 0; k < N_RES; k++)
            train[k] = bus.res_valid[k] && (!found || res_age[k] <= win_age);
        bus.rollback_en = found;
        bus.rollback_rob_idx = found ? bus.res_rob_idx[win] : '0;
        bus.rollback_pc = found ? res_corr[win] : '0;
    end

    always_comb begin
        logic [GHR_BITS-1:0] hist;
        logic [BHT_IDX_BITS-1:0] l_bht;
        logic [BTB_IDX_BITS-1:0] l_btb;
        logic l_hit, blocked;
        hist = ghr;
        blocked = 1'b0;
        l_bht = '0;
        l_btb = '0;
        l_hit = 1'b0;
        bus.pred_target = '0;
        for (int i = 0; i < N_FETCH; i++) begin
            l_bht = bus.fetch_pc[i][BHT_IDX_BITS+1:2] ^ (GSHARE ? BHT_IDX_BITS'(hist) : '0);
            l_btb = bus.fetch_pc[i][BTB_IDX_BITS+1:2];
            l_hit = btb_valid[l_btb] && btb_tag[l_btb] == bus.fetch_pc[i][BTB_TAG_BITS+BTB_IDX_BITS+1:BTB_IDX_BITS+2];
            bus.pred_ghr[i] = GSHARE ? hist : '0;
            bus.pred_taken[i] = bus.fetch_valid[i] && l_hit && (bus.fetch_is_uncond[i] || (bus.fetch_is_cond[i] && bht[l_bht][1]));
            bus.pred_valid[i] = bus.fetch_valid[i] && !blocked && !bus.rollback_en;
            if (bus.fetch_valid[i] && !blocked)
                bus.pred_target = bus.pred_taken[i] ? btb_target[l_btb] : bus.fetch_pc[i] + 64'd4;
            if (bus.fetch_valid[i] && bus.fetch_is_cond[i])
                hist = {hist[GHR_BITS-2:0], bus.pred_taken[i]};
            blocked = blocked | bus.pred_taken[i];
        end
        if (bus.rollback_en)
            bus.pred_target = bus.rollback_pc;
    end

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_next;

    // pred_valid already stops after the first taken lane
    always_comb begin
        ghr_next = ghr;
        for (int i = 0; i < N_FETCH; i++)
            if (bus.pred_valid[i] && bus.fetch_is_cond[i])
                ghr_next = {ghr_next[GHR_BITS-2:0], bus.pred_taken[i]};
        if (bus.rollback_en)
            ghr_next = bus.res_is_cond[win] ? {bus.res_ghr[win][GHR_BITS-2:0], bus.res_taken[win]} : bus.res_ghr[win];
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            ghr <= '0;
        else
            ghr <= ghr_next;
`else
    assign ghr = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < (1<<BHT_IDX_BITS); b++)
                bht[b] <= 2'b01;
            for (int b = 0; b < (1<<BTB_IDX_BITS); b++) begin
                btb_valid[b] <= 1'b0;
                btb_tag[b] <= '0;
                btb_target[b] <= '0;
            end
            bus.mispredict_cnt <= '0;
        end else begin
            // descending so the lowest port's write lands last on a shared entry
            for (int k = N_RES-1; k >= 0; k--) begin
                if (train[k] && bus.res_is_cond[k])
                    bht[res_bht[k]] <= bus.res_taken[k] ? ((bht[res_bht[k]] == 2'b11) ? 2'b11 : bht[res_bht[k]] + 2'd1)
                                                        : ((bht[res_bht[k]] == 2'b00) ? 2'b00 : bht[res_bht[k]] - 2'd1);
                if (train[k] && bus.res_taken[k]) begin
                    btb_valid[res_btb[k]] <= 1'b1;
                    btb_tag[res_btb[k]] <= res_tag[k];
                    btb_target[res_btb[k]] <= bus.res_target[k];
                end
            end
            if (bus.rollback_en && ~&bus.mispredict_cnt)
                bus.mispredict_cnt <= bus.mispredict_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_bp_gshare_tagged.sv
// tb_bp_gshare_tagged: directed scenarios plus randomized traffic checked against a behavioural predictor model.
module tb_bp_gshare_tagged;
`ifdef BP_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bp_gshare_tagged_if bus ();
    bp_gshare_tagged dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    int              m_bht [256];
    bit              m_bv  [64];
    int              m_btag[64];
    longint unsigned m_btgt[64];
    int              m_ghr;
    longint unsigned m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bidx(input longint unsigned pc, input int h);
        return int'((pc >> 2) & 255) ^ (GS ? h : 0);
    endfunction
    function automatic int widx(input longint unsigned pc);
        return int'((pc >> 2) & 63);
    endfunction
    function automatic int wtag(input longint unsigned pc);
        return int'((pc >> 8) & 1023);
    endfunction

    task automatic model_reset();
        foreach (m_bht[b]) m_bht[b] = 1;
        foreach (m_bv[b]) begin
            m_bv[b] = 0;
            m_btag[b] = 0;
            m_btgt[b] = 0;
        end
        m_ghr = 0;
        m_cnt = 0;
    endtask

    task automatic clear_in();
        bus.fetch_valid = '0; bus.fetch_pc = '0; bus.fetch_is_cond = '0; bus.fetch_is_uncond = '0;
        bus.res_valid = '0; bus.res_is_cond = '0; bus.res_pc = '0; bus.res_taken = '0;
        bus.res_target = '0; bus.res_pred_target = '0; bus.res_ghr = '0; bus.res_rob_idx = '0;
        bus.rob_head_idx = '0;
    endtask

    task automatic fetch(input int i, input longint unsigned pc, input bit cond, input bit uncond);
        bus.fetch_valid[i] = 1'b1; bus.fetch_pc[i] = pc;
        bus.fetch_is_cond[i] = cond; bus.fetch_is_uncond[i] = uncond;
    endtask

    task automatic resolve(input int k, input bit cond, input longint unsigned pc, input bit tk,
                           input longint unsigned tgt, input longint unsigned ptgt, input int g, input int rob);
        bus.res_valid[k] = 1'b1; bus.res_is_cond[k] = cond; bus.res_pc[k] = pc; bus.res_taken[k] = tk;
        bus.res_target[k] = tgt; bus.res_pred_target[k] = ptgt; bus.res_ghr[k] = 8'(g); bus.res_rob_idx[k] = 5'(rob);
    endtask

    // Predict, compare every output, then advance the model as the next edge would.
    task automatic settle();
        longint unsigned corr[2], pc, tgt;
        int age[2], w, h, spec;
        bit mis, rb, blk, hit, tk;
        logic [1:0] e_valid, e_taken;
        logic [15:0] e_ghr;
        bit bt[int];
        bit wt[int];
        #1;
        w = -1;
        for (int k = 0; k < 2; k++) begin
            corr[k] = bus.res_taken[k] ? bus.res_target[k] : bus.res_pc[k] + 4;
            age[k] = (int'(bus.res_rob_idx[k]) - int'(bus.rob_head_idx)) & 31;
            mis = bus.res_valid[k] && corr[k] != bus.res_pred_target[k];
            if (mis && (w < 0 || age[k] < age[w])) w = k;
        end
        rb = (w >= 0);
        h = m_ghr; spec = m_ghr; blk = 0; tgt = 0;
        for (int i = 0; i < 2; i++) begin
            pc = bus.fetch_pc[i];
            e_ghr[i*8 +: 8] = GS ? 8'(h) : 8'h00;
            hit = m_bv[widx(pc)] && m_btag[widx(pc)] == wtag(pc);
            tk = bus.fetch_valid[i] && hit && (bus.fetch_is_uncond[i] || (bus.fetch_is_cond[i] && m_bht[bidx(pc, h)] >= 2));
            e_taken[i] = tk;
            e_valid[i] = bus.fetch_valid[i] && !blk && !rb;
            if (bus.fetch_valid[i] && !blk) tgt = tk ? m_btgt[widx(pc)] : pc + 4;
            if (bus.fetch_valid[i] && bus.fetch_is_cond[i]) begin
                if (!blk) spec = ((spec << 1) | int'(tk)) & 255;
                h = ((h << 1) | int'(tk)) & 255;
            end
            blk = blk | tk;
        end
        if (rb) tgt = corr[w];
        check("pred_valid", 64'(bus.pred_valid), 64'(e_valid));
        check("pred_taken", 64'(bus.pred_taken), 64'(e_taken));
        check("pred_ghr", 64'(bus.pred_ghr), 64'(e_ghr));
        check("pred_target", bus.pred_target, tgt);
        check("rollback_en", 64'(bus.rollback_en), 64'(rb));
        check("rollback_rob_idx", 64'(bus.rollback_rob_idx), rb ? 64'(bus.res_rob_idx[w]) : 64'd0);
        check("rollback_pc", bus.rollback_pc, rb ? corr[w] : 64'd0);
        check("mispredict_cnt", 64'(bus.mispredict_cnt), m_cnt);
        for (int k = 0; k < 2; k++) begin
            if (!bus.res_valid[k] || (rb && age[k] > age[w])) continue;
            pc = bus.res_pc[k];
            if (bus.res_is_cond[k] && !bt.exists(bidx(pc, bus.res_ghr[k]))) begin
                int b = bidx(pc, bus.res_ghr[k]);
                bt[b] = 1;
                m_bht[b] = bus.res_taken[k] ? (m_bht[b] < 3 ? m_bht[b] + 1 : 3) : (m_bht[b] > 0 ? m_bht[b] - 1 : 0);
            end
            if (bus.res_taken[k] && !wt.exists(widx(pc))) begin
                wt[widx(pc)] = 1;
                m_bv[widx(pc)] = 1;
                m_btag[widx(pc)] = wtag(pc);
                m_btgt[widx(pc)] = bus.res_target[k];
            end
        end
        if (GS) m_ghr = !rb ? spec : bus.res_is_cond[w] ? ((int'(bus.res_ghr[w]) << 1) | int'(bus.res_taken[w])) & 255
                                                          : int'(bus.res_ghr[w]);
        if (rb && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic longint unsigned rand_pc();
        longint unsigned p = 64'h100 + 64'(4 * $urandom_range(0, 15));
        return ($urandom_range(0, 7) == 0) ? p + 64'h10000 : p;
    endfunction

    initial begin
        clear_in();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        settle();
        check("reset_cnt", 64'(bus.mispredict_cnt), 64'd0);
        reset_n = 1'b1;
        tick();

        fetch(0, 64'h100, 1, 0); fetch(1, 64'h104, 0, 0);
        settle();
        check("t1_taken", 64'(bus.pred_taken), 64'd0);
        check("t1_target", bus.pred_target, 64'h108);
        tick();

        clear_in();
        resolve(0, 1, 64'h100, 1, 64'h200, 64'h200, 0, 0);
        settle(); tick();
        settle(); tick();
        clear_in();
        fetch(0, 64'h100, 1, 0); fetch(1, 64'h104, 0, 0);
        settle();
        check("t2_taken", 64'(bus.pred_taken), 64'b01);
        check("t2_valid", 64'(bus.pred_valid), 64'b01);
        check("t2_target", bus.pred_target, 64'h200);
        tick();

        clear_in();
        bus.rob_head_idx = 5'd30;
        resolve(0, 1, 64'h140, 1, 64'h500, 64'h144, 0, 1);
        resolve(1, 1, 64'h180, 0, 64'h0, 64'h900, 0, 31);
        settle();
        check("t3_en", 64'(bus.rollback_en), 64'd1);
        check("t3_rob", 64'(bus.rollback_rob_idx), 64'd31);
        check("t3_pc", bus.rollback_pc, 64'h184);
        tick();
        clear_in();
        fetch(0, 64'h140, 0, 1);
        settle();
        check("t3_untrained", 64'(bus.pred_taken), 64'd0);
        tick();

        clear_in();
        resolve(0, 0, 64'h300, 1, 64'h400, 64'h400, 0, 5);
        resolve(1, 0, 64'h300, 1, 64'h800, 64'h800, 0, 5);
        settle(); tick();
        clear_in();
        fetch(0, 64'h300, 0, 1);
        settle();
        check("t4_target", bus.pred_target, 64'h400);
        tick();

        clear_in();
        resolve(0, 1, 64'h1C0, 1, 64'h600, 64'h1C4, 8'h5A, 3);
        fetch(0, 64'h100, 1, 0);
        settle();
        check("t6_valid", 64'(bus.pred_valid), 64'd0);
        check("t6_target", bus.pred_target, 64'h600);
        tick();
        clear_in();
        fetch(0, 64'h104, 1, 0);
        settle();
        check("t6_ghr", 64'(bus.pred_ghr[0]), GS ? 64'hB5 : 64'h0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            clear_in();
            if (c == 1500) begin
                reset_n = 1'b0;
                model_reset();
                settle();
                check("midreset_cnt", 64'(bus.mispredict_cnt), 64'd0);
                reset_n = 1'b1;
                tick();
                continue;
            end
            begin
                longint unsigned p = rand_pc();
                for (int i = 0; i < 2; i++) begin
                    int kind = $urandom_range(0, 3);
                    if ($urandom_range(0, 4) != 0) fetch(i, p + 64'(4 * i), kind == 1 || kind == 2, kind == 3);
                end
            end
            bus.rob_head_idx = 5'($urandom);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    longint unsigned pc = rand_pc();
                    longint unsigned tg = 64'h1000 + 64'(16 * $urandom_range(0, 3));
                    bit tk = 1'($urandom);
                    longint unsigned good = tk ? tg : pc + 4;
                    resolve(k, $urandom_range(0, 3) != 0, pc, tk, tg,
                            ($urandom_range(0, 5) == 0) ? good + 64'h40 : good, int'($urandom_range(0, 255)),
                            int'($urandom_range(0, 31)));
                end
            end
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
